// File: rtl/timer_arbiter_pkg.sv
// Shared types and default sizes for the flex-counter timer arbiter.
package timer_arbiter_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_NUM_CNT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        DONE
    } state_e;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  sel_o,
    output logic          valid_o
);

    int j;

    always_comb begin
        sel_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[j[IW-1:0]]) begin
                sel_o[j[IW-1:0]] = 1'b1;
                valid_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one flex counter between NUM_REQ interval requesters.
// Optional watchdog on the COUNT phase: define TIMER_ARBITER_WATCHDOG_EN.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_val,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic                            busy,
    output logic                            cnt_clear,
    output logic                            cnt_enable,
    output logic [NUM_CNT_BITS-1:0]         cnt_rollover_val,
    input  logic                            cnt_rollover_flag
`ifdef TIMER_ARBITER_WATCHDOG_EN
    ,
    output logic                            wdog_err
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int W  = NUM_CNT_BITS;

    state_e               state_q;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        rr_q;
    logic [W-1:0]         val_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 clr_q;

    logic [NUM_REQ-1:0]   pick_sel;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [W-1:0]         val_d;
    logic [IW-1:0]        rr_d;
    logic                 owner_req;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_q),
        .sel_o   (pick_sel),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_sel[i]) pick_idx = IW'(i);
        end
    end

    assign val_d     = req_val[pick_idx*W +: W];
    assign owner_req = req[idx_q];
    assign rr_d      = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

`ifdef TIMER_ARBITER_WATCHDOG_EN
    localparam int WD_TOP = (1 << W);
    logic [W:0] wd_q;
    logic       wdog_q;
    assign wdog_err = wdog_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            val_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            clr_q   <= 1'b1;
`ifdef TIMER_ARBITER_WATCHDOG_EN
            wd_q    <= '0;
            wdog_q  <= 1'b0;
`endif
        end else begin
            done_q <= '0;
            clr_q  <= 1'b0;
`ifdef TIMER_ARBITER_WATCHDOG_EN
            wdog_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    grant_q <= '0;
                    if (pick_valid) begin
                        state_q <= LOAD;
                        idx_q   <= pick_idx;
                        val_q   <= val_d;
                        grant_q <= pick_sel;
                        clr_q   <= 1'b1;
                    end
                end
                LOAD: begin
`ifdef TIMER_ARBITER_WATCHDOG_EN
                    wd_q <= '0;
`endif
                    if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        clr_q   <= 1'b1;
                    end else if (val_q == '0) begin
                        state_q <= DONE;
                        done_q  <= grant_q;
                    end else begin
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    // An owner that lets go forfeits its interval.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        clr_q   <= 1'b1;
                    end else if (cnt_rollover_flag) begin
                        state_q <= DONE;
                        done_q  <= grant_q;
                    end
`ifdef TIMER_ARBITER_WATCHDOG_EN
                    else if (wd_q == (W+1)'(WD_TOP)) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        clr_q   <= 1'b1;
                        wdog_q  <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    rr_q    <= rr_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant            = grant_q;
    assign done             = done_q;
    assign busy             = (state_q != IDLE);
    assign cnt_clear        = clr_q;
    assign cnt_enable       = (state_q == COUNT) && !cnt_rollover_flag;
    assign cnt_rollover_val = val_q;

endmodule
